// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with single-cycle logic ops and iterative unsigned mul/div
module alu_seq #(
    parameter int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_ctrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_n;
    logic [CNT_W-1:0] cnt;
    logic [1:0] op;
    logic [WIDTH:0] hi, hi_n, mul_sum, mul_hi, div_sh, div_tr, div_hi;
    logic [WIDTH-1:0] lo, lo_n, opb, mul_lo, div_lo, single, fin;
    logic is_iter, div_ok, last;

    assign in_ready  = state == IDLE;
    assign busy      = state == BUSY;
    assign out_valid = state == DONE;
    assign is_iter   = alu_ctrl[3:2] == 2'b10;
    assign last      = cnt == CNT_W'(1);

    // single-cycle legacy ops; undefined codes yield zero
    always_comb begin
        single = alu_ctrl == 4'b0000 ? a & b :
                 alu_ctrl == 4'b0001 ? a | b :
                 alu_ctrl == 4'b0010 ? a + b :
                 alu_ctrl == 4'b0110 ? a - b :
                 alu_ctrl == 4'b0111 ? {{(WIDTH-1){1'b0}}, a < b} :
                 alu_ctrl == 4'b1100 ? ~(a | b) : '0;
    end

    // one shift-add or restoring-division step; hi:lo is product or remainder:quotient
    always_comb begin
        mul_sum = hi + (lo[0] ? {1'b0, opb} : '0);
        mul_hi  = {1'b0, mul_sum[WIDTH:1]};
        mul_lo  = {mul_sum[0], lo[WIDTH-1:1]};
        div_sh  = {hi[WIDTH-1:0], lo[WIDTH-1]};
        div_tr  = div_sh - {1'b0, opb};
        div_ok  = !div_tr[WIDTH];
        div_hi  = div_ok ? div_tr : div_sh;
        div_lo  = {lo[WIDTH-2:0], div_ok};
        hi_n    = op[1] ? div_hi : mul_hi;
        lo_n    = op[1] ? div_lo : mul_lo;
        fin     = op[0] ? hi_n[WIDTH-1:0] : lo_n;
    end

    // next-state logic
    always_comb begin
        state_n = state;
        if (state == IDLE && in_valid)
            state_n = is_iter ? BUSY : DONE;
        else if (state == BUSY && last)
            state_n = DONE;
        else if (state == DONE && out_ready)
            state_n = IDLE;
    end

    // state register
    always_ff @(posedge clk) begin
        state <= reset ? IDLE : state_n;
    end

    // operand latch, iteration datapath and registered result
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            op     <= '0;
            opb    <= '0;
            hi     <= '0;
            lo     <= '0;
            result <= '0;
            zero   <= 1'b1;
        end else if (state == IDLE && in_valid) begin
            op  <= alu_ctrl[1:0];
            opb <= b;
            hi  <= '0;
            lo  <= a;
            cnt <= is_iter ? CNT_W'(WIDTH) : '0;
            if (!is_iter) begin
                result <= single;
                zero   <= single == '0;
            end
        end else if (state == BUSY) begin
            hi  <= hi_n;
            lo  <= lo_n;
            cnt <= cnt - 1'b1;
            if (last) begin
                result <= fin;
                zero   <= fin == '0;
            end
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed-vector bench for alu_seq at WIDTH=32 and WIDTH=8
module tb_alu_seq;
    logic clk = 0;
    logic reset;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic        in_valid, in_ready, out_valid, out_ready, zero, busy;
    logic [31:0] a, b, result;
    logic [3:0]  ctrl;

    logic        e_in_valid, e_in_ready, e_out_valid, e_out_ready, e_zero, e_busy;
    logic [7:0]  e_a, e_b, e_result;
    logic [3:0]  e_ctrl;

    alu_seq dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .alu_ctrl(ctrl), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .busy(busy)
    );

    alu_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .in_valid(e_in_valid), .in_ready(e_in_ready),
        .a(e_a), .b(e_b), .alu_ctrl(e_ctrl), .out_valid(e_out_valid), .out_ready(e_out_ready),
        .result(e_result), .zero(e_zero), .busy(e_busy)
    );

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic run32(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                         input logic hold, output logic [31:0] r, output logic z,
                         output int lat, output int bcnt);
        ctrl = op; a = x; b = y; in_valid = 1; out_ready = hold;
        @(negedge clk);
        in_valid = 0;
        lat = 1; bcnt = 0;
        while (!out_valid && lat < 100) begin
            if (busy) bcnt++;
            @(negedge clk);
            lat++;
        end
        r = result; z = zero;
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
    endtask

    task automatic run8(input logic [3:0] op, input logic [7:0] x, input logic [7:0] y,
                        output logic [7:0] r, output int lat, output int bcnt);
        e_ctrl = op; e_a = x; e_b = y; e_in_valid = 1; e_out_ready = 0;
        @(negedge clk);
        e_in_valid = 0;
        lat = 1; bcnt = 0;
        while (!e_out_valid && lat < 100) begin
            if (e_busy) bcnt++;
            @(negedge clk);
            lat++;
        end
        r = e_result;
        e_out_ready = 1;
        @(negedge clk);
        e_out_ready = 0;
    endtask

    task automatic test_reset();
        reset = 1; in_valid = 0; out_ready = 0; e_in_valid = 0; e_out_ready = 0;
        a = 0; b = 0; ctrl = 0; e_a = 0; e_b = 0; e_ctrl = 0;
        repeat (3) @(negedge clk);
        reset = 0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (result !== 32'h0) begin failures++; $display("FAIL reset_result: got %h want 0", result); end
        checks++; if (zero !== 1'b1) begin failures++; $display("FAIL reset_zero: got %b want 1", zero); end
        checks++; if (e_in_ready !== 1'b1 || e_result !== 8'h0) begin failures++; $display("FAIL reset_w8: in_ready %b result %h want 1 00", e_in_ready, e_result); end
    endtask

    task automatic test_legacy();
        logic [3:0]  ops [8] = '{4'b0010, 4'b0110, 4'b0111, 4'b0111, 4'b1100, 4'b0011, 4'b0000, 4'b0001};
        logic [31:0] xs  [8] = '{32'hFFFFFFFF, 32'd3, 32'd1, 32'hFFFFFFFF, 32'd0, 32'h12345678, 32'hF0F0F0F0, 32'hF0F0F0F0};
        logic [31:0] ys  [8] = '{32'd1, 32'd5, 32'hFFFFFFFF, 32'd1, 32'd0, 32'h9ABCDEF0, 32'hFF00FF00, 32'h0000FF00};
        logic [31:0] es  [8] = '{32'h0, 32'hFFFFFFFE, 32'd1, 32'd0, 32'hFFFFFFFF, 32'h0, 32'hF000F000, 32'hF0F0FFF0};
        logic [31:0] r;
        logic z;
        int lat, bc;
        for (int i = 0; i < 8; i++) begin
            run32(ops[i], xs[i], ys[i], 1'b0, r, z, lat, bc);
            checks++; if (r !== es[i]) begin failures++; $display("FAIL legacy_result[%0d]: got %h want %h", i, r, es[i]); end
            checks++; if (z !== (es[i] == 0)) begin failures++; $display("FAIL legacy_zero[%0d]: got %b want %b", i, z, es[i] == 0); end
            checks++; if (lat != 1) begin failures++; $display("FAIL legacy_latency[%0d]: got %0d want 1", i, lat); end
        end
    endtask

    task automatic test_mul();
        logic [3:0]  ops [4] = '{4'b1000, 4'b1001, 4'b1000, 4'b1001};
        logic [31:0] xs  [4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00010000, 32'h00010000};
        logic [31:0] ys  [4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00010000, 32'h00010000};
        logic [31:0] es  [4] = '{32'h00000001, 32'hFFFFFFFE, 32'h0, 32'h1};
        logic [31:0] r;
        logic z;
        int lat, bc;
        for (int i = 0; i < 4; i++) begin
            run32(ops[i], xs[i], ys[i], 1'b0, r, z, lat, bc);
            checks++; if (r !== es[i]) begin failures++; $display("FAIL mul_result[%0d]: got %h want %h", i, r, es[i]); end
            checks++; if (z !== (es[i] == 0)) begin failures++; $display("FAIL mul_zero[%0d]: got %b want %b", i, z, es[i] == 0); end
            checks++; if (lat != 33 || bc != 32) begin failures++; $display("FAIL mul_timing[%0d]: latency %0d busy %0d want 33 32", i, lat, bc); end
        end
    endtask

    task automatic test_div();
        logic [3:0]  ops [6] = '{4'b1010, 4'b1011, 4'b1010, 4'b1011, 4'b1010, 4'b1010};
        logic [31:0] xs  [6] = '{32'd100, 32'd100, 32'd9, 32'd9, 32'd0, 32'hFFFFFFFF};
        logic [31:0] ys  [6] = '{32'd7, 32'd7, 32'd0, 32'd0, 32'd5, 32'd1};
        logic [31:0] es  [6] = '{32'd14, 32'd2, 32'hFFFFFFFF, 32'd9, 32'd0, 32'hFFFFFFFF};
        logic [31:0] r;
        logic z;
        int lat, bc;
        for (int i = 0; i < 6; i++) begin
            run32(ops[i], xs[i], ys[i], 1'b0, r, z, lat, bc);
            checks++; if (r !== es[i]) begin failures++; $display("FAIL div_result[%0d]: got %h want %h", i, r, es[i]); end
            checks++; if (z !== (es[i] == 0)) begin failures++; $display("FAIL div_zero[%0d]: got %b want %b", i, z, es[i] == 0); end
            checks++; if (lat != 33 || bc != 32) begin failures++; $display("FAIL div_timing[%0d]: latency %0d busy %0d want 33 32", i, lat, bc); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r;
        logic z;
        int lat, bc, n;
        ctrl = 4'b0010; a = 2; b = 3; in_valid = 1; out_ready = 1; n = 0;
        repeat (8) begin @(negedge clk); if (out_valid) n++; end
        in_valid = 0; out_ready = 0;
        checks++; if (n != 4) begin failures++; $display("FAIL b2b_single: got %0d results want 4", n); end
        checks++; if (result !== 32'd5) begin failures++; $display("FAIL b2b_single_result: got %h want 5", result); end
        ctrl = 4'b1000; a = 2; b = 3; in_valid = 1; out_ready = 1; n = 0;
        repeat (68) begin @(negedge clk); if (out_valid) n++; end
        in_valid = 0; out_ready = 0;
        checks++; if (n != 2) begin failures++; $display("FAIL b2b_mul: got %0d results want 2", n); end
        checks++; if (result !== 32'd6) begin failures++; $display("FAIL b2b_mul_result: got %h want 6", result); end
        run32(4'b1001, 32'h80000000, 32'd4, 1'b1, r, z, lat, bc);
        checks++; if (r !== 32'd2 || lat != 33 || bc != 32) begin failures++; $display("FAIL ready_held_mulhu: result %h latency %0d busy %0d want 2 33 32", r, lat, bc); end
    endtask

    task automatic test_backpressure();
        logic [31:0] r;
        logic z;
        int lat, bc, bad;
        ctrl = 4'b1000; a = 6; b = 7; in_valid = 1; out_ready = 0;
        @(negedge clk);
        in_valid = 0; lat = 1;
        while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
        checks++; if (lat != 33) begin failures++; $display("FAIL bp_latency: got %0d want 33", lat); end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin ctrl = 4'b0010; a = 1; b = 1; in_valid = 1; end
            if (result !== 32'd42 || in_ready !== 1'b0 || out_valid !== 1'b1 || zero !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL bp_hold: %0d unstable cycles want 0 (result %h)", bad, result); end
        in_valid = 0; out_ready = 1;
        @(negedge clk);
        out_ready = 0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL bp_consume: out_valid %b in_ready %b want 0 1", out_valid, in_ready); end
        checks++; if (result !== 32'd42) begin failures++; $display("FAIL bp_ignored_input: got %h want 2a", result); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_once: out_valid %b want 0", out_valid); end
        run32(4'b0010, 32'd1, 32'd2, 1'b0, r, z, lat, bc);
        checks++; if (r !== 32'd3 || lat != 1) begin failures++; $display("FAIL bp_next_op: result %h latency %0d want 3 1", r, lat); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] r;
        logic z;
        int lat, bc;
        ctrl = 4'b1010; a = 100; b = 7; in_valid = 1; out_ready = 0;
        @(negedge clk);
        in_valid = 0;
        repeat (9) @(negedge clk);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midreset_busy_before: got %b want 1", busy); end
        reset = 1;
        @(negedge clk);
        reset = 0;
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL midreset_ctrl: busy %b out_valid %b in_ready %b want 0 0 1", busy, out_valid, in_ready); end
        checks++; if (result !== 32'h0 || zero !== 1'b1) begin failures++; $display("FAIL midreset_result: result %h zero %b want 0 1", result, zero); end
        run32(4'b0010, 32'd5, 32'd7, 1'b0, r, z, lat, bc);
        checks++; if (r !== 32'd12 || lat != 1) begin failures++; $display("FAIL midreset_add: result %h latency %0d want c 1", r, lat); end
    endtask

    task automatic test_width8();
        logic [3:0] ops [4] = '{4'b1000, 4'b1001, 4'b1010, 4'b1011};
        logic [7:0] xs  [4] = '{8'hFF, 8'hFF, 8'd200, 8'd200};
        logic [7:0] ys  [4] = '{8'hFF, 8'hFF, 8'd3, 8'd3};
        logic [7:0] es  [4] = '{8'h01, 8'hFE, 8'd66, 8'd2};
        logic [7:0] r;
        int lat, bc;
        for (int i = 0; i < 4; i++) begin
            run8(ops[i], xs[i], ys[i], r, lat, bc);
            checks++; if (r !== es[i]) begin failures++; $display("FAIL w8_result[%0d]: got %h want %h", i, r, es[i]); end
            checks++; if (lat != 9 || bc != 8) begin failures++; $display("FAIL w8_timing[%0d]: latency %0d busy %0d want 9 8", i, lat, bc); end
        end
    endtask

    initial begin
        test_reset();
        test_legacy();
        test_mul();
        test_div();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_width8();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the single-cycle datapath ALU. It keeps the existing six-operation `alu_ctrl` encoding and adds iterative unsigned multiply and divide (MUL, MULHU, DIVU, REMU). Operands enter through a valid/ready input port, and results leave through a registered valid/ready output port. The block sits between the register-read stage and writeback of the multi-cycle core, which stalls on `in_ready`/`out_valid`.

## Interface
- `WIDTH`, 32: operand and result width; must be ≥ 4.
- `CNT_W`, $clog2(WIDTH)+1: iteration counter width; derived, not overridden.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: operands and op presented.
- `in_ready` out 1: block can accept; high only in IDLE.
- `a` in WIDTH: operand A.
- `b` in WIDTH: operand B.
- `alu_ctrl` in 4: operation select.
- `out_valid` out 1: `result`/`zero` valid.
- `out_ready` in 1: consumer accepts the result.
- `result` out WIDTH: registered result.
- `zero` out 1: registered, `result == 0`.
- `busy` out 1: high in BUSY.

## Operation
- Op encoding (all unsigned):
  - 0000 AND
  - 0001 OR
  - 0010 ADD (mod 2^WIDTH)
  - 0110 SUB (mod 2^WIDTH)
  - 0111 SLTU (1 if a<b else 0)
  - 1100 NOR
  - 1000 MUL (low WIDTH bits of a*b)
  - 1001 MULHU (high WIDTH bits of a*b)
  - 1010 DIVU (a/b)
  - 1011 REMU (a mod b)
  - any other code: result 0, `zero` 1, single-cycle path.
- FSM states and transitions:
  - IDLE: accept when `in_valid && in_ready`; operands and op are latched.
    - Single-cycle op: go to DONE.
    - Mul/div op: go to BUSY with counter = WIDTH.
  - BUSY: one iteration per cycle; counter decrements; at counter==1 the final iteration completes and the state goes to DONE.
  - DONE: `out_valid`=1. On `out_ready`, go to IDLE. `result`/`zero` hold stable until accepted.
- MUL/MULHU: shift-add over a 2*WIDTH product register; iterate on multiplier LSB; one bit per cycle.
- DIVU/REMU: restoring division; one quotient bit per cycle; WIDTH-bit remainder plus 1 guard bit.
- Divide by zero follows the RISC-V rule: DIVU returns all ones, REMU returns `a`. It still takes WIDTH cycles, and no exception is raised.
- Inputs are ignored outside IDLE. There is no queueing, so at most one operation is in flight.
- Result is accepted back-to-back: the next op is accepted no earlier than the cycle after DONE→IDLE, because `in_ready` is low in DONE.

## Timing
- Reset values (any state, including mid-BUSY; the in-flight op is discarded):
  - state IDLE, counter 0, `result` 0, `zero` 1.
  - `out_valid` 0, `busy` 0, `in_ready` 1 in the cycle after reset deasserts.
- Single-cycle ops: accepted at edge N; `out_valid`=1 after edge N+1 (latency 1).
- Mul/div: accepted at edge N; `busy` high for exactly WIDTH cycles; `out_valid`=1 after edge N+WIDTH+1. Latency is WIDTH+1, independent of operand values.
- Throughput, with `out_ready` held high:
  - single-cycle op: one op per 2 cycles.
  - mul/div: one op per WIDTH+2 cycles.
- `out_ready` high in DONE at edge M: `out_valid` drops and `in_ready` rises after edge M.
- `out_ready` low: DONE is held indefinitely with outputs unchanged.
- `out_ready` asserted while not in DONE has no effect.
- `in_valid` with an undefined `alu_ctrl` is accepted normally.
- `zero` is always consistent with the registered `result` in the same cycle.

## Test plan
- Reset mid-DIVU:
  - Stimulus: WIDTH=32, DIVU 100/7 accepted; `reset` pulsed at BUSY cycle 10.
  - Required: next cycle `busy`=0, `out_valid`=0, `result`=0, `zero`=1, `in_ready`=1. A following ADD 5+7 returns 12 after 1 cycle.
- Legacy ops, each one latency 1:
  - ADD 0xFFFFFFFF+1 → 0, `zero`=1.
  - SUB 3-5 → 0xFFFFFFFE.
  - SLTU 1<0xFFFFFFFF → 1.
  - NOR 0,0 → 0xFFFFFFFF.
  - Code 0011 → 0, `zero`=1.
- Multiply:
  - MUL 0xFFFFFFFF*0xFFFFFFFF → 0x00000001; MULHU of the same → 0xFFFFFFFE.
  - Both have `busy` high for exactly 32 cycles and `out_valid` at cycle 33.
- Divide:
  - DIVU 100/7 → 14; REMU 100/7 → 2.
  - DIVU 9/0 → 0xFFFFFFFF; REMU 9/0 → 9.
  - DIVU 0/5 → 0, `zero`=1.
- Backpressure:
  - Stimulus: MUL 6*7 with `out_ready` low for 20 cycles after `out_valid`.
  - Required: `result`=42 stable, `in_ready`=0, and a new `in_valid` is ignored. On `out_ready` the result is consumed once; the next op is accepted the following cycle.
- Parameter sweep:
  - WIDTH=8: MUL 0xFF*0xFF → 0x01, MULHU → 0xFE, DIVU 200/3 → 66, REMU 200/3 → 2.
  - Each mul/div has latency 9 cycles.
